p2_video_scan: RTL and testbench

P2_VIDEO_SCAN -- requirements
Module: p2_video_scan

---
 rtl/p2_video_scan.sv | 146 ++++++++++++++
 tb/tb_p2_video_scan.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/p2_video_scan.sv
// Raster scan generator for a 1-bpp framebuffer: sync/blank timing, VRAM word
// prefetch, and a 16-bit serializer, all advancing on the pixel tick.
module p2_video_scan #(
    parameter int H_ACTIVE = 1152,
    parameter int H_FP     = 32,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 192,
    parameter int V_ACTIVE = 900,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        video_en,
    output logic [16:0] vram_addr,
    output logic        vram_rd,
    input  logic [15:0] vram_data,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        blank_n,
    output logic        pixel,
    output logic        vblank_irq
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PRE    = HW'(H_TOTAL - 2);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_LS = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [16:0]   LINE_B   = 17'(H_ACTIVE / 8);

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          en_q, en_d;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   shift_q, shift_d;
    logic          rd_pend_q, rd_pend_d;
    logic          hsync_n_q, hsync_n_d;
    logic          vsync_n_q, vsync_n_d;
    logic          blank_n_q, blank_n_d;
    logic          pixel_q, pixel_d;
    logic          vblank_irq_q, vblank_irq_d;

    logic          h_pre, h_last, v_last;
    logic [HW-1:0] fetch_h, load_h;
    logic [VW-1:0] fetch_v;
    logic          fetch_en;
    logic          frame_start, en_eff, active, load;

    // Fetch target is two pixels ahead; near end of line it belongs to the
    // next line, and at end of frame it is gated by the live enable because
    // the latched one is only refreshed at frame start.
    always_comb begin
        h_pre     = hcount_q >= H_PRE;
        v_last    = vcount_q == V_LAST;
        fetch_h   = h_pre ? hcount_q - H_PRE : hcount_q + HW'(2);
        fetch_v   = !h_pre ? vcount_q : (v_last ? '0 : vcount_q + VW'(1));
        fetch_en  = (h_pre && v_last) ? video_en : en_q;
        vram_rd   = !reset && pix_en && fetch_en && (fetch_h[3:0] == 4'd0)
                    && (fetch_h < H_ACT) && (fetch_v < V_ACT);
        vram_addr = vram_rd ? (17'(fetch_v) * LINE_B + 17'(fetch_h >> 3)) : '0;
    end

    always_comb begin
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        en_d         = en_q;
        shift_d      = shift_q;
        hsync_n_d    = hsync_n_q;
        vsync_n_d    = vsync_n_q;
        blank_n_d    = blank_n_q;
        pixel_d      = pixel_q;
        vblank_irq_d = 1'b0;
        rd_pend_d    = vram_rd;
        hold_d       = rd_pend_q ? vram_data : hold_q;

        h_last      = hcount_q == H_LAST;
        load_h      = h_last ? '0 : hcount_q + HW'(1);
        load        = (load_h[3:0] == 4'd0) && (load_h < H_ACT);
        frame_start = (hcount_q == '0) && (vcount_q == '0);
        en_eff      = frame_start ? video_en : en_q;
        active      = (hcount_q < H_ACT) && (vcount_q < V_ACT);

        if (pix_en) begin
            hcount_d = h_last ? '0 : hcount_q + HW'(1);
            if (h_last)
                vcount_d = v_last ? '0 : vcount_q + VW'(1);
            if (frame_start)
                en_d = video_en;
            blank_n_d    = active;
            hsync_n_d    = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
            vsync_n_d    = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
            pixel_d      = active && en_eff && shift_q[15];
            // Load may land on the clk the read data arrives; bypass the holding register then.
            shift_d      = load ? (rd_pend_q ? vram_data : hold_q) : {shift_q[14:0], 1'b0};
            vblank_irq_d = h_last && (vcount_q == V_ACT_LS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q     <= '0;
            vcount_q     <= V_ACT;
            en_q         <= 1'b0;
            hold_q       <= '0;
            shift_q      <= '0;
            rd_pend_q    <= 1'b0;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
            blank_n_q    <= 1'b0;
            pixel_q      <= 1'b0;
            vblank_irq_q <= 1'b0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            en_q         <= en_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            rd_pend_q    <= rd_pend_d;
            hsync_n_q    <= hsync_n_d;
            vsync_n_q    <= vsync_n_d;
            blank_n_q    <= blank_n_d;
            pixel_q      <= pixel_d;
            vblank_irq_q <= vblank_irq_d;
        end
    end

    assign hsync_n    = hsync_n_q;
    assign vsync_n    = vsync_n_q;
    assign blank_n    = blank_n_q;
    assign pixel      = pixel_q;
    assign vblank_irq = vblank_irq_q;

endmodule

// File: tb/tb_p2_video_scan.sv
// Randomized bench for p2_video_scan on a reduced raster, checked against a
// position/framebuffer model of the display rules.
module tb_p2_video_scan;

    localparam int HA = 64, HF = 8, HS = 16, HB = 8;
    localparam int VA = 6, VF = 1, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int WPL = HA / 16;
    localparam int MEMW = VA * WPL;

    logic        clk = 1'b0;
    logic        reset, pix_en, video_en;
    logic [16:0] vram_addr;
    logic        vram_rd;
    logic [15:0] vram_data = '0;
    logic        hsync_n, vsync_n, blank_n, pixel, vblank_irq;

    p2_video_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .video_en(video_en),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n),
        .pixel(pixel), .vblank_irq(vblank_irq)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:MEMW-1];

    always @(posedge clk)
        if (vram_rd)
            vram_data <= (int'(vram_addr[16:1]) < MEMW) ? mem[int'(vram_addr[16:1])] : 16'hdead;

    int n_vec = 0, n_err = 0;
    int mh, mv;
    bit fen, ve_drive;
    bit e_hs, e_vs, e_bl, e_px, e_irq;
    int rd_count, irq_count, hs_low, vs_low, last_addr;
    int clk_idx = 0, last_fall, hs_period;
    bit prev_hs = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (pos h=%0d v=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    task automatic clear_stats();
        rd_count = 0; irq_count = 0; hs_low = 0; vs_low = 0;
        last_addr = -1; last_fall = -1; hs_period = 0;
    endtask

    // Expected read for the current position: the pixel two ticks ahead starts a word.
    task automatic exp_fetch(output bit erd, output int eaddr);
        int  t, line;
        bit  wrapped, en;
        t       = (mh + 2) % HT;
        wrapped = (mh + 2) >= HT;
        line    = wrapped ? (mv + 1) % VT : mv;
        en      = (wrapped && mv == VT - 1) ? ve_drive : fen;
        erd     = (t % 16 == 0) && (t < HA) && (line < VA) && en;
        eaddr   = line * (HA / 8) + 2 * (t / 16);
    endtask

    task automatic cycle(input bit rst, input bit pe);
        bit          erd;
        int          eaddr;
        logic [15:0] w;
        reset = rst; pix_en = pe; video_en = ve_drive;
        #1;
        exp_fetch(erd, eaddr);
        if (rst || !pe) erd = 1'b0;
        check_eq("vram_rd", vram_rd, erd);
        if (erd) check_eq("vram_addr", vram_addr, eaddr);
        else if (rst) check_eq("vram_addr_rst", vram_addr, 0);
        if (vram_rd) begin rd_count++; last_addr = vram_addr; end
        @(posedge clk); #1;
        clk_idx++;
        if (rst) begin
            mh = 0; mv = VA; fen = 1'b0;
            e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_px = 1'b0; e_irq = 1'b0;
        end else if (pe) begin
            if (mh == 0 && mv == 0) fen = ve_drive;
            e_bl = (mh < HA) && (mv < VA);
            e_hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
            e_vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
            e_px = 1'b0;
            if (e_bl && fen) begin
                w    = mem[mv * WPL + mh / 16];
                e_px = w[15 - mh % 16];
            end
            e_irq = (mh == HT - 1) && (mv == VA - 1);
            mh = mh + 1;
            if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
            if (!hsync_n) hs_low++;
            if (!vsync_n) vs_low++;
        end else begin
            e_irq = 1'b0;
        end
        check_eq("hsync_n", hsync_n, e_hs);
        check_eq("vsync_n", vsync_n, e_vs);
        check_eq("blank_n", blank_n, e_bl);
        check_eq("pixel", pixel, e_px);
        check_eq("vblank_irq", vblank_irq, e_irq);
        if (vblank_irq) irq_count++;
        if (!hsync_n && prev_hs) begin
            if (last_fall >= 0) hs_period = clk_idx - last_fall;
            last_fall = clk_idx;
        end
        prev_hs = hsync_n;
    endtask

    // mode 0: pix_en always 1, mode 1: alternating 1/0, mode 2: random
    task automatic run_ticks(input int n, input int mode);
        int done = 0;
        bit ph = 1'b1, pe;
        while (done < n) begin
            pe = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom % 3 != 0);
            ph = !ph;
            cycle(1'b0, pe);
            if (pe) done++;
        end
    endtask

    task automatic run_to(input int th, input int tv, input int mode);
        int guard = 0;
        while (!(mh == th && mv == tv) && guard < 4 * HT * VT) begin
            cycle(1'b0, (mode == 0) ? 1'b1 : ($urandom % 3 != 0));
            guard++;
        end
        if (guard >= 4 * HT * VT) check_eq("run_to_reach", mv * HT + mh, tv * HT + th);
    endtask

    initial begin
        for (int i = 0; i < MEMW; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8001;
        mh = 0; mv = VA; fen = 1'b0; ve_drive = 1'b1;
        e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_px = 1'b0; e_irq = 1'b0;
        clear_stats();

        repeat (3) cycle(1'b1, 1'b1);

        clear_stats();
        run_ticks(HT * VT, 0);
        check_eq("frame_reads", rd_count, VA * WPL);
        check_eq("frame_irqs", irq_count, 1);
        check_eq("hsync_low_ticks", hs_low, HS * VT);
        check_eq("vsync_low_ticks", vs_low, VS * HT);
        check_eq("hsync_period", hs_period, HT);
        check_eq("last_addr", last_addr, VA * HA / 8 - 2);

        clear_stats();
        run_ticks(HT * VT, 1);
        check_eq("alt_reads", rd_count, VA * WPL);
        check_eq("alt_hsync_period", hs_period, 2 * HT);
        check_eq("alt_irqs", irq_count, 1);

        clear_stats();
        run_to(0, 2, 0);
        ve_drive = 1'b0;
        run_to(0, VA, 0);
        check_eq("drop_frame_reads", rd_count, VA * WPL);
        clear_stats();
        run_ticks(HT * VT, 0);
        check_eq("disabled_frame_reads", rd_count, 0);

        ve_drive = 1'b1;
        clear_stats();
        run_ticks(HT * VT, 2);
        check_eq("rand_frame_reads", rd_count, VA * WPL);

        run_to(37, 3, 0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        clear_stats();
        run_ticks(HT * VT, 2);
        check_eq("post_reset_reads", rd_count, VA * WPL);
        check_eq("post_reset_irqs", irq_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
